// File: rtl/cpu_run_pkg.sv
// Shared types and default sizing for the CPU run controller and its trace FIFO.
package cpu_run_pkg;

  localparam int PC_W_DEF         = 8;
  localparam int DATA_W_DEF       = 8;
  localparam int INSTR_W_DEF      = 16;
  localparam int RESET_CYCLES_DEF = 2;
  localparam int MAX_CYCLES_DEF   = 15;
  localparam int HALT_REPEAT_DEF  = 3;
  localparam int TRACE_DEPTH_DEF  = 16;

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [DATA_W_DEF-1:0]  alu;
    logic [INSTR_W_DEF-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// Trace FIFO: synchronous push/pop, registered 1-cycle read, flush, registered flags.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok, push_ok;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    push_drop = push && !push_ok;
    wptr_n    = wptr + (AW+1)'(push_ok);
    rptr_n    = rptr + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      empty    <= (wptr_n == rptr_n);
      full     <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= mem[rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 8-bit RISC CPU: reset sequencing, halt/timeout detection, trace capture.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int INSTR_W      = INSTR_W_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter int HALT_REPEAT  = HALT_REPEAT_DEF,
  parameter int TRACE_DEPTH  = TRACE_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PC_W-1:0]             current_pc,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic [INSTR_W-1:0]          instruction,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        done,
  output logic                        halted,
  output logic                        timeout,
  output logic [15:0]                 cycle_count,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [PC_W+DATA_W+INSTR_W-1:0] rd_data,
  output logic                        trace_empty,
  output logic                        trace_full,
  output logic                        trace_overflow
);

  localparam int TW  = PC_W + DATA_W + INSTR_W;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int RPW = $clog2(HALT_REPEAT + 1);

  state_t           state;
  logic [RCW-1:0]   rst_cnt;
  logic [RPW-1:0]   repeat_cnt, rep_next;
  logic [PC_W-1:0]  prev_pc_p1;
  logic [15:0]      cnt_next;
  logic             start_ok, sample, halt_hit, tout_hit, push_drop;

  always_comb begin
    start_ok = start && (state == IDLE || state == DONE);
    sample   = (state == RUN) && !abort;
    cnt_next = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
    // repeat_cnt==0 marks the first sample of a run, which has no previous PC.
    rep_next = (repeat_cnt != '0 && current_pc == prev_pc_p1) ? repeat_cnt + RPW'(1) : RPW'(1);
    halt_hit = (rep_next == RPW'(HALT_REPEAT));
    tout_hit = (cnt_next >= 16'(MAX_CYCLES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      halted         <= 1'b0;
      timeout        <= 1'b0;
      cycle_count    <= '0;
      repeat_cnt     <= '0;
      rst_cnt        <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_drop) trace_overflow <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RESET;
            cpu_reset      <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            halted         <= 1'b0;
            timeout        <= 1'b0;
            cycle_count    <= '0;
            repeat_cnt     <= '0;
            trace_overflow <= 1'b0;
            rst_cnt        <= RCW'(RESET_CYCLES - 1);
          end
        end
        RESET: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rst_cnt == '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cycle_count <= cnt_next;
            repeat_cnt  <= rep_next;
            // Halt takes priority when both end conditions land on the same sample.
            if (halt_hit || tout_hit) begin
              state     <= DONE;
              cpu_reset <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              halted    <= halt_hit;
              timeout   <= !halt_hit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sample) prev_pc_p1 <= current_pc;
  end

  trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start_ok),
    .push      (sample),
    .push_data ({current_pc, alu_result, instruction}),
    .pop       (rd_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .empty     (trace_empty),
    .full      (trace_full),
    .push_drop (push_drop)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: default instance plus a MAX_CYCLES=20 instance for overflow.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, abort = 1'b0, rd_en = 1'b0;
  logic [7:0]  current_pc = '0, alu_result = '0;
  logic [15:0] instruction = '0;

  logic        cpu_reset, busy, done, halted, timeout, rd_valid, trace_empty, trace_full, trace_overflow;
  logic [15:0] cycle_count;
  logic [31:0] rd_data;
  logic        cpu_reset_b, busy_b, done_b, halted_b, timeout_b, rd_valid_b, trace_empty_b, trace_full_b, trace_overflow_b;
  logic [15:0] cycle_count_b;
  logic [31:0] rd_data_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .current_pc(current_pc), .alu_result(alu_result), .instruction(instruction),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .halted(halted), .timeout(timeout),
    .cycle_count(cycle_count), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .trace_empty(trace_empty), .trace_full(trace_full), .trace_overflow(trace_overflow)
  );

  cpu_run_ctrl #(.MAX_CYCLES(20)) dut20 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .current_pc(current_pc), .alu_result(alu_result), .instruction(instruction),
    .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b), .halted(halted_b), .timeout(timeout_b),
    .cycle_count(cycle_count_b), .rd_en(rd_en), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .trace_empty(trace_empty_b), .trace_full(trace_full_b), .trace_overflow(trace_overflow_b)
  );

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_entry_t ent(input logic [7:0] pc);
    trace_entry_t e;
    e.pc    = pc;
    e.alu   = pc + 8'h10;
    e.instr = {8'hA0, pc};
    return e;
  endfunction

  task automatic sample(input logic [7:0] pc);
    current_pc  = pc;
    alu_result  = pc + 8'h10;
    instruction = {8'hA0, pc};
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic rd(input logic exp_valid, input trace_entry_t exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    ck("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) ck("rd_data", rd_data, exp);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    ck("rst_cpu_reset", 32'(cpu_reset), 1);
    ck("rst_busy", 32'(busy), 0);
    ck("rst_done", 32'(done), 0);
    ck("rst_halted", 32'(halted), 0);
    ck("rst_timeout", 32'(timeout), 0);
    ck("rst_rd_valid", 32'(rd_valid), 0);
    ck("rst_full", 32'(trace_full), 0);
    ck("rst_ovf", 32'(trace_overflow), 0);
    ck("rst_empty", 32'(trace_empty), 1);
    ck("rst_count", 32'(cycle_count), 0);
    ck("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    tick();

    // Basic run: RESET window is exactly two cycles, then RUN with cpu_reset low
    start = 1'b1;
    tick();
    start = 1'b0;
    ck("basic_busy_r1", 32'(busy), 1);
    ck("basic_cpurst_r1", 32'(cpu_reset), 1);
    tick();
    ck("basic_cpurst_r2", 32'(cpu_reset), 1);
    tick();
    ck("basic_cpurst_run", 32'(cpu_reset), 0);
    ck("basic_busy_run", 32'(busy), 1);

    // Halt: PC 0,1,2,3,3,3
    sample(8'd0); sample(8'd1); sample(8'd2); sample(8'd3); sample(8'd3);
    ck("halt_not_yet", 32'(done), 0);
    ck("halt_busy5", 32'(busy), 1);
    sample(8'd3);
    ck("halt_done", 32'(done), 1);
    ck("halt_halted", 32'(halted), 1);
    ck("halt_timeout", 32'(timeout), 0);
    ck("halt_count", 32'(cycle_count), 6);
    ck("halt_cpurst", 32'(cpu_reset), 1);
    ck("halt_busy", 32'(busy), 0);
    rd(1'b1, ent(8'd0)); rd(1'b1, ent(8'd1)); rd(1'b1, ent(8'd2));
    rd(1'b1, ent(8'd3)); rd(1'b1, ent(8'd3)); rd(1'b1, ent(8'd3));
    ck("halt_empty", 32'(trace_empty), 1);
    rd(1'b0, ent(8'd0));

    // Timeout: PC increments, default budget 15
    start_run();
    for (int i = 0; i < 15; i++) sample(8'(i));
    ck("to_done", 32'(done), 1);
    ck("to_timeout", 32'(timeout), 1);
    ck("to_halted", 32'(halted), 0);
    ck("to_count", 32'(cycle_count), 15);
    ck("to_ovf", 32'(trace_overflow), 0);
    for (int i = 0; i < 15; i++) rd(1'b1, ent(8'(i)));
    rd(1'b0, ent(8'd0));

    // Simultaneous halt and timeout on the 15th sample
    start_run();
    for (int i = 0; i < 12; i++) sample(8'(i));
    sample(8'd7); sample(8'd7); sample(8'd7);
    ck("sim_done", 32'(done), 1);
    ck("sim_halted", 32'(halted), 1);
    ck("sim_timeout", 32'(timeout), 0);
    ck("sim_count", 32'(cycle_count), 15);

    // Restart from DONE with a full-ish trace flushes and clears flags
    ck("restart_pre_empty", 32'(trace_empty), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ck("restart_empty", 32'(trace_empty), 1);
    ck("restart_halted", 32'(halted), 0);
    ck("restart_done", 32'(done), 0);
    ck("restart_count", 32'(cycle_count), 0);
    tick();
    tick();

    // Abort on the deciding cycle wins
    for (int i = 0; i < 12; i++) sample(8'(i));
    sample(8'd7); sample(8'd7);
    abort = 1'b1;
    sample(8'd7);
    abort = 1'b0;
    ck("abort_busy", 32'(busy), 0);
    ck("abort_done", 32'(done), 0);
    ck("abort_cpurst", 32'(cpu_reset), 1);
    ck("abort_halted", 32'(halted), 0);

    // Overflow on the MAX_CYCLES=20 instance, no reads
    start_run();
    for (int i = 0; i < 16; i++) sample(8'(i));
    ck("ovf_full16", 32'(trace_full_b), 1);
    ck("ovf_not_yet", 32'(trace_overflow_b), 0);
    sample(8'd16);
    ck("ovf_set", 32'(trace_overflow_b), 1);
    for (int i = 17; i < 20; i++) sample(8'(i));
    ck("ovf_done", 32'(done_b), 1);
    ck("ovf_timeout", 32'(timeout_b), 1);
    ck("ovf_count", 32'(cycle_count_b), 20);
    ck("ovf_sticky", 32'(trace_overflow_b), 1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      ck("ovf_rd_valid", 32'(rd_valid_b), 1);
      ck("ovf_rd_data", rd_data_b, ent(8'(i)));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    ck("ovf_rd17", 32'(rd_valid_b), 0);

    // Restart clears sticky overflow; asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    ck("ovf_cleared", 32'(trace_overflow_b), 0);
    tick();
    tick();
    sample(8'd1); sample(8'd2); sample(8'd3);
    ck("mid_busy_pre", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    ck("mid_busy", 32'(busy), 0);
    ck("mid_cpurst", 32'(cpu_reset), 1);
    ck("mid_count", 32'(cycle_count), 0);
    ck("mid_empty", 32'(trace_empty), 1);
    ck("mid_rd_data", rd_data, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
